// File: rtl/fht_pkg.sv
// Shared constants and types for the FHT sequencer.
// N_POINTS points are held in N_BANK banks of BANK_SIZE words. Each of the
// N_STAGES stages streams BANK_SIZE reads and then drains a butterfly pipeline
// of PIPE_LAT cycles.
package fht_pkg;

    localparam int N_POINTS  = 1024;
    localparam int N_BANK    = 4;
    localparam int BANK_SIZE = 256;
    localparam int A_BIT     = 8;
    localparam int N_STAGES  = 10;
    localparam int PIPE_LAT  = 4;

    // Cycles per stage: reads plus the pipeline drain.
    localparam int STAGE_LEN = BANK_SIZE + PIPE_LAT;
    // Counter widths: cnt_stage holds 0..9, cnt_stage_time holds 0..259.
    localparam int S_BIT     = 4;
    localparam int T_BIT     = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/fht_addr_gen.sv
// Combinational address generator for one FHT stage cycle.
// Ports:
//   stage     - current stage index (0..N_STAGES-1)
//   t         - cycle within the stage (0..STAGE_LEN-1)
//   addr_rd   - bank read address: t rotated left by (stage mod 8); 0 once t >= BANK_SIZE
//   addr_coef - twiddle ROM address: (t mod 2^m) << (8-m), m = min(stage, 8)
module fht_addr_gen
    import fht_pkg::*;
(
    input  logic [S_BIT-1:0] stage,
    input  logic [T_BIT-1:0] t,
    output logic [A_BIT-1:0] addr_rd,
    output logic [A_BIT-1:0] addr_coef
);

    logic [2*A_BIT-1:0] doubled;
    logic [S_BIT-1:0]   m;
    logic [A_BIT:0]     mask_wide;

    always_comb begin
        // Rotating a byte is a shift of the byte concatenated with itself;
        // the upper half is the rotated value.
        doubled   = {t[A_BIT-1:0], t[A_BIT-1:0]} << stage[2:0];
        addr_rd   = t[A_BIT] ? '0 : doubled[2*A_BIT-1:A_BIT];

        // Coefficient span grows one bit per stage and saturates at 8 bits;
        // stage 0 needs only W^0, hence address 0.
        m         = (stage >= S_BIT'(8)) ? S_BIT'(8) : stage;
        mask_wide = ((A_BIT+1)'(1) << m) - (A_BIT+1)'(1);
        addr_coef = (t[A_BIT-1:0] & mask_wide[A_BIT-1:0]) << (S_BIT'(8) - m);
    end

endmodule

// File: rtl/fht_control.sv
// Sequencer for a 1024-point, 4-bank, radix-2 FHT.
// Ports:
//   iCLK, iRESET           - rising-edge clock, synchronous active-high reset
//   iSTART                 - one-cycle start pulse, honoured only while idle
//   oADDR_RD_0..3          - bank read addresses (all banks share one address)
//   oADDR_WR_0..3          - bank write addresses, read address delayed by PIPE_LAT
//   oADDR_COEF             - twiddle-coefficient ROM address
//   oWE_A, oWE_B           - write enable of memory set A / set B
//   oSOURCE_DATA           - set being read (0 = A, 1 = B); writes go to the other
//   oSOURCE_CONT           - 1 while the transform owns the memories
//   oST_ZERO, oST_LAST     - first / last stage active
//   o2ND_PART_SUBSEC       - read pointer in the upper half of the bank
//   oSECTOR                - read pointer quarter, t[7:6]
//   oRDY                   - 1 when idle or done
// Every output is a flop. The combinational block computes the next counter
// values and derives each output from them, so outputs line up with the
// counters they describe.
module fht_control
    import fht_pkg::*;
(
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    output logic [A_BIT-1:0] oADDR_RD_0,
    output logic [A_BIT-1:0] oADDR_RD_1,
    output logic [A_BIT-1:0] oADDR_RD_2,
    output logic [A_BIT-1:0] oADDR_RD_3,
    output logic [A_BIT-1:0] oADDR_WR_0,
    output logic [A_BIT-1:0] oADDR_WR_1,
    output logic [A_BIT-1:0] oADDR_WR_2,
    output logic [A_BIT-1:0] oADDR_WR_3,
    output logic [A_BIT-1:0] oADDR_COEF,
    output logic             oWE_A,
    output logic             oWE_B,
    output logic             oSOURCE_DATA,
    output logic             oSOURCE_CONT,
    output logic             oST_ZERO,
    output logic             oST_LAST,
    output logic             o2ND_PART_SUBSEC,
    output logic [1:0]       oSECTOR,
    output logic             oRDY
);

    state_t           state, state_nx;
    logic [S_BIT-1:0] cnt_stage, cnt_stage_nx;
    logic [T_BIT-1:0] cnt_stage_time, cnt_stage_time_nx;
    logic             clk_2, clk_2_nx;

    // Read addresses of the last PIPE_LAT cycles; the oldest entry becomes
    // the write address.
    logic [A_BIT-1:0] rd_pipe [PIPE_LAT];

    logic [A_BIT-1:0] gen_rd, gen_coef;

    logic [A_BIT-1:0] addr_rd_nx, addr_wr_nx, addr_coef_nx;
    logic             we_a_nx, we_b_nx, source_data_nx, run_nx, writing_nx;
    logic             second_half_nx;
    logic [1:0]       sector_nx;

    logic [A_BIT-1:0] addr_rd_q, addr_wr_q, addr_coef_q;
    logic             we_a_q, we_b_q, source_data_q, source_cont_q;
    logic             st_zero_q, st_last_q, second_half_q, rdy_q;
    logic [1:0]       sector_q;

    fht_addr_gen u_addr_gen (
        .stage     (cnt_stage_nx),
        .t         (cnt_stage_time_nx),
        .addr_rd   (gen_rd),
        .addr_coef (gen_coef)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the branches can leave a value unassigned and infer a latch.
        state_nx          = state;
        cnt_stage_nx      = cnt_stage;
        cnt_stage_time_nx = cnt_stage_time;
        clk_2_nx          = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (iSTART) begin
                    state_nx          = ST_RUN;
                    cnt_stage_nx      = '0;
                    cnt_stage_time_nx = '0;
                end
            end
            ST_RUN: begin
                clk_2_nx = ~clk_2;
                if (cnt_stage_time == T_BIT'(STAGE_LEN - 1)) begin
                    cnt_stage_time_nx = '0;
                    if (cnt_stage == S_BIT'(N_STAGES - 1)) begin
                        state_nx     = ST_IDLE;
                        cnt_stage_nx = '0;
                        clk_2_nx     = 1'b0;
                    end else begin
                        cnt_stage_nx = cnt_stage + S_BIT'(1);
                    end
                end else begin
                    cnt_stage_time_nx = cnt_stage_time + T_BIT'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        run_nx     = (state_nx == ST_RUN);
        writing_nx = run_nx
                     && (cnt_stage_time_nx >= T_BIT'(PIPE_LAT))
                     && (cnt_stage_time_nx <= T_BIT'(PIPE_LAT + BANK_SIZE - 1));

        // Even stages read set A, odd stages read set B; stage 9 therefore
        // leaves the result in set A, which is what idle reports.
        source_data_nx = run_nx & cnt_stage_nx[0];
        we_a_nx        = writing_nx &  source_data_nx;
        we_b_nx        = writing_nx & ~source_data_nx;

        addr_rd_nx     = run_nx     ? gen_rd   : '0;
        addr_coef_nx   = run_nx     ? gen_coef : '0;
        addr_wr_nx     = writing_nx ? rd_pipe[PIPE_LAT-1] : '0;

        sector_nx      = (run_nx && !cnt_stage_time_nx[T_BIT-1])
                         ? cnt_stage_time_nx[A_BIT-1:A_BIT-2] : 2'b00;
        second_half_nx = run_nx && !cnt_stage_time_nx[T_BIT-1]
                         && cnt_stage_time_nx[A_BIT-1];
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state          <= ST_IDLE;
            cnt_stage      <= '0;
            cnt_stage_time <= '0;
            clk_2          <= 1'b0;
            // NOTE: the delay line is only PIPE_LAT flops, so it is cleared
            // with the rest of the state instead of being left unknown.
            for (int i = 0; i < PIPE_LAT; i++) rd_pipe[i] <= '0;
            addr_rd_q      <= '0;
            addr_wr_q      <= '0;
            addr_coef_q    <= '0;
            we_a_q         <= 1'b0;
            we_b_q         <= 1'b0;
            source_data_q  <= 1'b0;
            source_cont_q  <= 1'b0;
            st_zero_q      <= 1'b0;
            st_last_q      <= 1'b0;
            second_half_q  <= 1'b0;
            sector_q       <= 2'b00;
            rdy_q          <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop here sample the
            // pre-edge values, which is what lets the delay line shift.
            state          <= state_nx;
            cnt_stage      <= cnt_stage_nx;
            cnt_stage_time <= cnt_stage_time_nx;
            clk_2          <= clk_2_nx;
            rd_pipe[0]     <= addr_rd_nx;
            for (int i = 1; i < PIPE_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            addr_rd_q      <= addr_rd_nx;
            addr_wr_q      <= addr_wr_nx;
            addr_coef_q    <= addr_coef_nx;
            we_a_q         <= we_a_nx;
            we_b_q         <= we_b_nx;
            source_data_q  <= source_data_nx;
            source_cont_q  <= run_nx;
            st_zero_q      <= run_nx && (cnt_stage_nx == '0);
            st_last_q      <= run_nx && (cnt_stage_nx == S_BIT'(N_STAGES - 1));
            second_half_q  <= second_half_nx;
            sector_q       <= sector_nx;
            rdy_q          <= ~run_nx;
        end
    end

    assign oADDR_RD_0       = addr_rd_q;
    assign oADDR_RD_1       = addr_rd_q;
    assign oADDR_RD_2       = addr_rd_q;
    assign oADDR_RD_3       = addr_rd_q;
    assign oADDR_WR_0       = addr_wr_q;
    assign oADDR_WR_1       = addr_wr_q;
    assign oADDR_WR_2       = addr_wr_q;
    assign oADDR_WR_3       = addr_wr_q;
    assign oADDR_COEF       = addr_coef_q;
    assign oWE_A            = we_a_q;
    assign oWE_B            = we_b_q;
    assign oSOURCE_DATA     = source_data_q;
    assign oSOURCE_CONT     = source_cont_q;
    assign oST_ZERO         = st_zero_q;
    assign oST_LAST         = st_last_q;
    assign o2ND_PART_SUBSEC = second_half_q;
    assign oSECTOR          = sector_q;
    assign oRDY             = rdy_q;

endmodule

// File: tb/tb_fht_control.sv
// Self-checking bench for fht_control. A behavioural model tracks only
// "running" and the cycle index k since start; every expected output is
// derived from k with plain arithmetic (stage = k/260, t = k%260).
module tb_fht_control;

    logic       iCLK = 1'b0;
    logic       iRESET, iSTART;
    logic [7:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
    logic [7:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
    logic [7:0] oADDR_COEF;
    logic       oWE_A, oWE_B, oSOURCE_DATA, oSOURCE_CONT;
    logic       oST_ZERO, oST_LAST, o2ND_PART_SUBSEC, oRDY;
    logic [1:0] oSECTOR;

    fht_control dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
        .oADDR_RD_0(oADDR_RD_0), .oADDR_RD_1(oADDR_RD_1),
        .oADDR_RD_2(oADDR_RD_2), .oADDR_RD_3(oADDR_RD_3),
        .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1),
        .oADDR_WR_2(oADDR_WR_2), .oADDR_WR_3(oADDR_WR_3),
        .oADDR_COEF(oADDR_COEF), .oWE_A(oWE_A), .oWE_B(oWE_B),
        .oSOURCE_DATA(oSOURCE_DATA), .oSOURCE_CONT(oSOURCE_CONT),
        .oST_ZERO(oST_ZERO), .oST_LAST(oST_LAST),
        .o2ND_PART_SUBSEC(o2ND_PART_SUBSEC), .oSECTOR(oSECTOR), .oRDY(oRDY)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state.
    bit m_run = 1'b0;
    int m_k   = 0;

    typedef struct {
        logic       rdy, cont, st_zero, st_last, src, we_a, we_b, sub2;
        logic [1:0] sector;
        logic [7:0] rd, wr, coef;
    } exp_t;

    function automatic int rotl8(int v, int r);
        return ((v << r) | (v >> (8 - r))) & 255;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   stage, t, mm;
        e = '{default: '0};
        e.rdy = 1'b1;
        if (!m_run) return e;
        stage     = m_k / 260;
        t         = m_k % 260;
        mm        = (stage < 8) ? stage : 8;
        e.rdy     = 1'b0;
        e.cont    = 1'b1;
        e.st_zero = (stage == 0);
        e.st_last = (stage == 9);
        e.src     = stage[0];
        e.we_a    = (t >= 4) && stage[0];
        e.we_b    = (t >= 4) && !stage[0];
        e.rd      = (t < 256) ? 8'(rotl8(t, stage % 8)) : 8'd0;
        e.wr      = (t >= 4) ? 8'(rotl8(t - 4, stage % 8)) : 8'd0;
        e.coef    = 8'(((t % (1 << mm)) << (8 - mm)) & 255);
        e.sector  = (t < 256) ? 2'(t / 64) : 2'd0;
        e.sub2    = (t >= 128) && (t < 256);
        return e;
    endfunction

    // One clock: the model consumes the inputs present at the edge, then
    // outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge iCLK);
        if (iRESET) begin
            m_run = 1'b0;
            m_k   = 0;
        end else if (m_run) begin
            if (m_k == 2599) begin
                m_run = 1'b0;
                m_k   = 0;
            end else begin
                m_k++;
            end
        end else if (iSTART) begin
            m_run = 1'b1;
            m_k   = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        iRESET = 1'b1;
        iSTART = 1'b1;   // coincident with reset: must be ignored
        repeat (3) tick();
        iSTART = 1'b0;
        n_checks++;
        if (oRDY !== 1'b1 || oSOURCE_CONT !== 1'b0 || oST_ZERO !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: rdy=%b cont=%b st_zero=%b, expected 1 0 0",
                     oRDY, oSOURCE_CONT, oST_ZERO);
        end
        iRESET = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            n_checks++;
            if (oRDY !== 1'b1 || oWE_A !== 1'b0 || oWE_B !== 1'b0 ||
                oSOURCE_CONT !== 1'b0 || oSOURCE_DATA !== 1'b0 ||
                oADDR_RD_0 !== 8'd0 || oADDR_WR_0 !== 8'd0) begin
                n_fail++;
                $display("FAIL idle c=%0d: rdy=%b we=%b%b cont=%b src=%b rd=%0d wr=%0d, expected 1 00 0 0 0 0",
                         c, oRDY, oWE_A, oWE_B, oSOURCE_CONT, oSOURCE_DATA, oADDR_RD_0, oADDR_WR_0);
            end
        end
    endtask

    // Full transform with spurious iSTART pulses; every cycle is compared
    // against the model.
    task automatic test_full_run();
        exp_t e;
        int   cycles = 0, writes = 0, last_cyc = 0;
        bit   done = 1'b0;
        repeat ($urandom_range(0, 20)) tick();
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        n_checks++;
        if (oRDY !== 1'b0 || oST_ZERO !== 1'b1 || oADDR_RD_0 !== 8'd0) begin
            n_fail++;
            $display("FAIL start: rdy=%b st_zero=%b rd=%0d, expected 0 1 0", oRDY, oST_ZERO, oADDR_RD_0);
        end
        for (int c = 0; c < 2700 && !done; c++) begin
            iSTART = m_run && ($urandom_range(0, 15) == 0);
            tick();
            iSTART = 1'b0;
            cycles++;
            e = model_out();
            if (oWE_A === 1'b1 || oWE_B === 1'b1) writes++;
            if (oST_LAST === 1'b1) last_cyc++;
            n_checks++;
            if ({oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3} !== {4{e.rd}}) begin
                n_fail++;
                $display("FAIL rd k=%0d: got %0d %0d %0d %0d, expected %0d",
                         m_k, oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3, e.rd);
            end
            n_checks++;
            if ({oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3} !== {4{e.wr}}) begin
                n_fail++;
                $display("FAIL wr k=%0d: got %0d %0d %0d %0d, expected %0d",
                         m_k, oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3, e.wr);
            end
            n_checks++;
            if (oADDR_COEF !== e.coef) begin
                n_fail++;
                $display("FAIL coef k=%0d: got %0d, expected %0d", m_k, oADDR_COEF, e.coef);
            end
            n_checks++;
            if ({oWE_A, oWE_B, oSOURCE_DATA} !== {e.we_a, e.we_b, e.src}) begin
                n_fail++;
                $display("FAIL we_src k=%0d: got %b%b%b, expected %b%b%b",
                         m_k, oWE_A, oWE_B, oSOURCE_DATA, e.we_a, e.we_b, e.src);
            end
            n_checks++;
            if ({oRDY, oSOURCE_CONT, oST_ZERO, oST_LAST, o2ND_PART_SUBSEC, oSECTOR} !==
                {e.rdy, e.cont, e.st_zero, e.st_last, e.sub2, e.sector}) begin
                n_fail++;
                $display("FAIL flags k=%0d: got %b%b%b%b%b%b, expected %b%b%b%b%b%b", m_k,
                         oRDY, oSOURCE_CONT, oST_ZERO, oST_LAST, o2ND_PART_SUBSEC, oSECTOR,
                         e.rdy, e.cont, e.st_zero, e.st_last, e.sub2, e.sector);
            end
            if (m_run && m_k == 261) begin
                n_checks++;
                if (oADDR_RD_0 !== 8'd2) begin
                    n_fail++;
                    $display("FAIL stage1_t1: rd=%0d, expected 2", oADDR_RD_0);
                end
            end
            if (m_run && m_k == 3 * 260 + 5) begin
                n_checks++;
                if (oADDR_RD_0 !== 8'd40 || oADDR_COEF !== 8'd160 || oWE_A !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stage3_t5: rd=%0d coef=%0d we_a=%b, expected 40 160 1",
                             oADDR_RD_0, oADDR_COEF, oWE_A);
                end
            end
            if (oRDY === 1'b1) done = 1'b1;
        end
        n_checks++;
        if (!done || cycles != 2600) begin
            n_fail++;
            $display("FAIL run_length: rdy rose after %0d cycles (done=%0d), expected 2600", cycles, done);
        end
        n_checks++;
        if (writes != 2560) begin
            n_fail++;
            $display("FAIL write_count: got %0d, expected 2560", writes);
        end
        n_checks++;
        if (last_cyc != 260) begin
            n_fail++;
            $display("FAIL st_last_count: got %0d, expected 260", last_cyc);
        end
    endtask

    // Start on the very cycle after done.
    task automatic test_back_to_back();
        exp_t e;
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        for (int c = 0; c < 300; c++) begin
            e = model_out();
            n_checks++;
            if (oRDY !== e.rdy || oADDR_RD_2 !== e.rd || oADDR_WR_3 !== e.wr ||
                oWE_B !== e.we_b || oADDR_COEF !== e.coef) begin
                n_fail++;
                $display("FAIL b2b k=%0d: rdy=%b rd=%0d wr=%0d we_b=%b coef=%0d, expected %b %0d %0d %b %0d",
                         m_k, oRDY, oADDR_RD_2, oADDR_WR_3, oWE_B, oADDR_COEF,
                         e.rdy, e.rd, e.wr, e.we_b, e.coef);
            end
            tick();
        end
    endtask

    // Abort at stage 4, t=100, then restart from stage 0.
    task automatic test_reset_mid_run();
        exp_t e;
        int   hold;
        for (int c = 0; c < 3000 && !(m_run && m_k == 4 * 260 + 100); c++) begin
            if (!m_run) iSTART = 1'b1;
            tick();
            iSTART = 1'b0;
        end
        n_checks++;
        if (!(m_run && m_k == 4 * 260 + 100) || oADDR_RD_1 !== 8'(rotl8(100, 4))) begin
            n_fail++;
            $display("FAIL abort_point: k=%0d rd=%0d, expected k=1140 rd=%0d",
                     m_k, oADDR_RD_1, rotl8(100, 4));
        end
        iRESET = 1'b1;
        hold = $urandom_range(1, 3);
        for (int c = 0; c < hold; c++) begin
            iSTART = (c == hold - 1);
            tick();
            n_checks++;
            if (oRDY !== 1'b1 || oWE_A !== 1'b0 || oWE_B !== 1'b0 || oSOURCE_CONT !== 1'b0 ||
                oADDR_RD_0 !== 8'd0 || oADDR_WR_0 !== 8'd0 || oST_ZERO !== 1'b0) begin
                n_fail++;
                $display("FAIL abort c=%0d: rdy=%b we=%b%b cont=%b rd=%0d wr=%0d st0=%b, expected 1 00 0 0 0 0",
                         c, oRDY, oWE_A, oWE_B, oSOURCE_CONT, oADDR_RD_0, oADDR_WR_0, oST_ZERO);
            end
        end
        iRESET = 1'b0;
        iSTART = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        for (int c = 0; c < 12; c++) begin
            e = model_out();
            n_checks++;
            if (oST_ZERO !== e.st_zero || oADDR_RD_0 !== e.rd || oWE_B !== e.we_b ||
                oADDR_WR_1 !== e.wr || oRDY !== e.rdy) begin
                n_fail++;
                $display("FAIL restart k=%0d: st0=%b rd=%0d we_b=%b wr=%0d rdy=%b, expected %b %0d %b %0d %b",
                         m_k, oST_ZERO, oADDR_RD_0, oWE_B, oADDR_WR_1, oRDY,
                         e.st_zero, e.rd, e.we_b, e.wr, e.rdy);
            end
            tick();
        end
    endtask

    initial begin
        iRESET = 1'b1;
        iSTART = 1'b0;
        test_reset();
        test_full_run();
        n_checks++;
        if (oSOURCE_DATA !== 1'b0 || oRDY !== 1'b1) begin
            n_fail++;
            $display("FAIL done_state: src=%b rdy=%b, expected 0 1", oSOURCE_DATA, oRDY);
        end
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
